// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer: op codes, FSM state encoding, function-code width.
package alu_pkg;

  localparam int unsigned ALU_FC_W = 4;

  localparam logic [ALU_FC_W-1:0] ALU_OP_AND  = 4'd0;
  localparam logic [ALU_FC_W-1:0] ALU_OP_OR   = 4'd1;
  localparam logic [ALU_FC_W-1:0] ALU_OP_ADD  = 4'd2;
  localparam logic [ALU_FC_W-1:0] ALU_OP_ZERO = 4'd3;
  localparam logic [ALU_FC_W-1:0] ALU_OP_ANDN = 4'd4;
  localparam logic [ALU_FC_W-1:0] ALU_OP_ORN  = 4'd5;
  localparam logic [ALU_FC_W-1:0] ALU_OP_SUB  = 4'd6;
  localparam logic [ALU_FC_W-1:0] ALU_OP_SLT  = 4'd7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic logic op_legal(input logic [ALU_FC_W-1:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_issuer.sv
// Command/response initiator wrapped around a combinational ALU.
// Optional ALU_ISSUER_PERF_EN adds completed-response and illegal-op counters.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int unsigned NBIT = 32
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [ALU_FC_W-1:0] i_cmd_op,
  input  logic [NBIT-1:0]     i_cmd_a,
  input  logic [NBIT-1:0]     i_cmd_b,
  output logic [NBIT-1:0]     o_alu_a,
  output logic [NBIT-1:0]     o_alu_b,
  output logic [ALU_FC_W-1:0] o_alu_fc,
  input  logic [NBIT-1:0]     i_alu_data,
  input  logic                i_alu_cout,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [NBIT-1:0]     o_rsp_data,
  output logic                o_rsp_cout,
  output logic                o_rsp_zero,
  output logic                o_rsp_err
`ifdef ALU_ISSUER_PERF_EN
  ,
  output logic [31:0]         o_op_cnt,
  output logic [15:0]         o_err_cnt
`endif
);

  state_t              state, state_nxt;
  logic                cmd_ready_nxt;
  logic [NBIT-1:0]     alu_a_nxt, alu_b_nxt, rsp_data_nxt;
  logic [ALU_FC_W-1:0] alu_fc_nxt;
  logic                rsp_valid_nxt, rsp_cout_nxt, rsp_zero_nxt, rsp_err_nxt;

  // Next-state and next-output decode; every register holds unless a transition updates it.
  always_comb begin
    state_nxt     = state;
    alu_a_nxt     = o_alu_a;
    alu_b_nxt     = o_alu_b;
    alu_fc_nxt    = o_alu_fc;
    rsp_valid_nxt = o_rsp_valid;
    rsp_data_nxt  = o_rsp_data;
    rsp_cout_nxt  = o_rsp_cout;
    rsp_zero_nxt  = o_rsp_zero;
    rsp_err_nxt   = o_rsp_err;
    case (state)
      ST_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          if (op_legal(i_cmd_op)) begin
            alu_a_nxt  = i_cmd_a;
            alu_b_nxt  = i_cmd_b;
            alu_fc_nxt = i_cmd_op;
            state_nxt  = ST_EXEC;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = '0;
            rsp_cout_nxt  = 1'b0;
            rsp_zero_nxt  = 1'b0;
            rsp_err_nxt   = 1'b1;
            state_nxt     = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        // The ALU carry is only meaningful for ADD; other ops leave it stale.
        rsp_valid_nxt = 1'b1;
        rsp_data_nxt  = i_alu_data;
        rsp_cout_nxt  = (o_alu_fc == ALU_OP_ADD) ? i_alu_cout : 1'b0;
        rsp_zero_nxt  = (i_alu_data == '0);
        rsp_err_nxt   = 1'b0;
        alu_fc_nxt    = ALU_OP_ZERO;
        state_nxt     = ST_RESP;
      end
      ST_RESP: begin
        if (o_rsp_valid && i_rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_nxt = 1'b0;
        state_nxt     = ST_IDLE;
      end
    endcase
    cmd_ready_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      o_cmd_ready <= 1'b0;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_fc    <= ALU_OP_ZERO;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_cout  <= 1'b0;
      o_rsp_zero  <= 1'b0;
      o_rsp_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_cmd_ready <= cmd_ready_nxt;
      o_alu_a     <= alu_a_nxt;
      o_alu_b     <= alu_b_nxt;
      o_alu_fc    <= alu_fc_nxt;
      o_rsp_valid <= rsp_valid_nxt;
      o_rsp_data  <= rsp_data_nxt;
      o_rsp_cout  <= rsp_cout_nxt;
      o_rsp_zero  <= rsp_zero_nxt;
      o_rsp_err   <= rsp_err_nxt;
    end
  end

`ifdef ALU_ISSUER_PERF_EN
  // Counters advance on each completed response handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_op_cnt  <= '0;
      o_err_cnt <= '0;
    end else if (o_rsp_valid && i_rsp_ready) begin
      o_op_cnt <= o_op_cnt + 32'd1;
      if (o_rsp_err && (o_err_cnt != 16'hFFFF))
        o_err_cnt <= o_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
Command-side initiator for the combinational NBIT ALU. It accepts operation commands over a valid/ready interface and drives the ALU operand and function-code inputs. It captures the ALU result and carry-out, then returns them over a valid/ready response interface. It sits between a host/sequencer and the ALU and owns all timing around the ALU's combinational path.

Parameters:
NBIT, 32, operand/result width; must match the attached ALU.

Ports:
i_clk  input  1  clock, rising edge.
i_rstn  input  1  reset; synchronous, active-low.
i_cmd_valid  input  1  command present.
o_cmd_ready  output  1  issuer can accept a command.
i_cmd_op  input  4  requested operation code.
i_cmd_a  input  NBIT  operand A.
i_cmd_b  input  NBIT  operand B.
o_alu_a  output  NBIT  registered operand A to ALU.
o_alu_b  output  NBIT  registered operand B to ALU.
o_alu_fc  output  4  function code to ALU.
i_alu_data  input  NBIT  ALU result.
i_alu_cout  input  1  ALU carry-out.
o_rsp_valid  output  1  response present.
i_rsp_ready  input  1  consumer takes the response.
o_rsp_data  output  NBIT  captured result.
o_rsp_cout  output  1  captured carry (ADD only).
o_rsp_zero  output  1  captured result equals 0.
o_rsp_err  output  1  illegal op code.

Behaviour:
- Reset is synchronous, active-low, on i_clk. On reset:
  - state goes to IDLE.
  - o_cmd_ready=0 in the reset cycle and 1 in the first cycle after reset releases.
  - o_alu_a=0, o_alu_b=0, o_alu_fc=4'b0011 (zero op).
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_cout=0, o_rsp_zero=0, o_rsp_err=0.
- Legal op codes are 0..7: AND, OR, ADD, ZERO, ANDN, ORN, SUB, SLT. Codes 8..15 are illegal.
- FSM states and transitions:
  - IDLE: o_cmd_ready=1. On i_cmd_valid & o_cmd_ready:
    - Legal op: latch i_cmd_a/i_cmd_b into o_alu_a/o_alu_b, latch op into o_alu_fc, go to EXEC.
    - Illegal op: do not change the ALU outputs; load response with data=0, cout=0, zero=0, err=1; go to RESP.
  - EXEC: one cycle for the ALU path to settle, with o_cmd_ready=0. At the end of the cycle:
    - capture o_rsp_data=i_alu_data.
    - o_rsp_cout = i_alu_cout if fc==2, else 0. The ALU holds stale carry for other ops, so it must be masked.
    - o_rsp_zero = (i_alu_data==0); o_rsp_err=0.
    - Set o_rsp_valid=1, set o_alu_fc=4'b0011, go to RESP.
  - RESP: hold o_rsp_valid and all response fields stable until i_rsp_ready. On o_rsp_valid & i_rsp_ready: clear o_rsp_valid, go to IDLE.
- Latency:
  - Command accepted at edge T → o_rsp_valid high after edge T+1 (legal op) or after edge T (illegal op).
  - Minimum throughput: one command per 3 cycles (legal) or per 2 cycles (illegal).
- o_cmd_ready is a pure function of state (IDLE) and never depends on i_cmd_valid.
- No command is accepted while a response is pending; back-pressure holds RESP indefinitely.
- i_cmd_* is sampled only on the handshake edge; later changes are ignored.
- Reset mid-operation (EXEC or RESP): the in-flight command and response are discarded, and all outputs take their reset values.
- Width rule: all operands and results are exactly NBIT bits. There is no sign extension. The result of SLT is whatever the ALU returns.

Optional Feature:
Macro ALU_ISSUER_PERF_EN.
- Defined:
  - Adds output port o_op_cnt [31:0], counting completed response handshakes (legal and illegal). It wraps 0xFFFFFFFF→0 and resets to 0.
  - Adds output o_err_cnt [15:0], counting illegal-op responses; it saturates at 0xFFFF.
- Undefined: neither port nor either counter exists. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - op-code constants: ALU_OP_AND=0, OR=1, ADD=2, ZERO=3, ANDN=4, ORN=5, SUB=6, SLT=7.
  - the state encoding typedef: IDLE, EXEC, RESP.
  - ALU_FC_W=4.
- No sub-module. The FSM and capture registers form one module. The testbench instantiates alu_issuer together with the ALU.

Test Plan:
- ADD, NBIT=32, a=0xFFFFFFFF, b=0x00000001, rsp_ready=1 → data=0x00000000, cout=1, zero=1, err=0. rsp_valid rises 2 edges after the accept edge.
- AND a=0xF0F0F0F0 b=0xFF00FF00 issued right after an ADD with carry → data=0xF000F000, cout=0 (masked), zero=0.
- Op=4'b1010 → no ALU operand change; rsp within 1 edge with err=1, data=0. With ALU_ISSUER_PERF_EN defined, o_err_cnt increments by 1.
- Hold i_rsp_ready=0 for 10 cycles after an OR response, with new i_cmd_valid asserted throughout → o_cmd_ready=0 and fields stable. Release ready → one handshake, then IDLE and the next command is accepted.
- Assert i_rstn=0 for 1 cycle while in EXEC → next cycle all outputs at reset values and o_rsp_valid never rises for that command.
- With ALU_ISSUER_PERF_EN defined, 5 back-to-back legal commands → o_op_cnt=5. With the macro undefined, the build has no o_op_cnt and the other results are unchanged.
